// File: rtl/result_fifo.sv
// result_fifo: FIFO buffering results from the exponential datapath for the readout path.
// Latency: a write is readable on the next cycle; rd_data/rd_valid appear one cycle after an accepted rd_req.
// Backpressure: none. A write while full is dropped and sets overflow; a read while empty is ignored and sets underflow.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   wr_req, wr_data   - single-cycle write strobe and result word
//   rd_req            - single-cycle read strobe
//   rd_data, rd_valid - registered output word and its one-cycle valid
//   full, empty, count- occupancy decodes of the count register
//   overflow,underflow- sticky error flags, cleared only by rst
module result_fifo #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              rd_acc;
  logic              wr_acc;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A read frees a slot in the same cycle, so a write into a full FIFO is
  // accepted when paired with a read (wp == rp then, and the read samples the
  // old word before the write lands).
  assign rd_acc = rd_req && !empty;
  assign wr_acc = wr_req && (!full || rd_acc);

  // Storage has no reset: contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wp <= wp + ADDR_W'(1);
      end
      if (rd_acc) begin
        rp      <= rp + ADDR_W'(1);
        rd_data <= mem[rp];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (wr_req && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_req && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: self-checking bench for result_fifo against a queue-based reference model.
// Latency: one step per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: none; stimulus drives strobes freely including full/empty corner cases.
module tb_result_fifo;

  localparam int DATA_W = 21;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus expected registered outputs.
  logic [DATA_W-1:0] q [$];
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ovf;
  logic              m_udf;

  result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // Called 1 unit after a rising edge; pulses reset well before the next edge.
  task automatic apply_reset();
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    rst     = 1'b1;
    #3;
    rst     = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model applies the FIFO rules to the queue.
  task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rd);
    bit rd_ok;
    bit wr_ok;
    wr_req  = wr;
    wr_data = d;
    rd_req  = rd;
    rd_ok   = rd && (q.size() > 0);
    wr_ok   = wr && ((q.size() < DEPTH) || rd_ok);
    m_valid = 1'b0;
    if (rd_ok) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else if (rd) begin
      m_udf = 1'b1;
    end
    if (wr_ok) q.push_back(d);
    else if (wr) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 7;
    if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    if (count !== 4'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    if (rd_data !== '0)     begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 21'h000100;
    vals[1] = 21'h00A5A5;
    vals[2] = 21'h1FFFFF;
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, vals[i], 1'b0);
    checks++;
    if (count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      checks += 2;
      if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, rd_valid); end
      if (rd_data !== vals[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, rd_data, vals[i]); end
      step(1'b0, '0, 1'b0);
      checks += 2;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop[%0d]: got %b expected 0", i, rd_valid); end
      if (rd_data !== vals[i]) begin errors++; $display("FAIL basic_data_hold[%0d]: got %h expected %h", i, rd_data, vals[i]); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_end: got %b expected 1", empty); end
  endtask

  task automatic test_full_overflow();
    apply_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
    checks += 2;
    if (full !== 1'b1)  begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
    step(1'b1, DATA_W'(9), 1'b0);
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    if (count !== 4'd8)    begin errors++; $display("FAIL ovf_count_after: got %0d expected 8", count); end
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      checks += 2;
      if (rd_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid[%0d]: got %b expected 1", i, rd_valid); end
      if (rd_data !== DATA_W'(i)) begin errors++; $display("FAIL ovf_drain_data[%0d]: got %h expected %h", i, rd_data, DATA_W'(i)); end
    end
    step(1'b0, '0, 1'b1);
    checks += 4;
    if (rd_valid !== 1'b0)  begin errors++; $display("FAIL ovf_no_ninth: got %b expected 0", rd_valid); end
    if (rd_data !== 21'd8)  begin errors++; $display("FAIL ovf_data_hold: got %h expected 8", rd_data); end
    if (underflow !== 1'b1) begin errors++; $display("FAIL ovf_underflow: got %b expected 1", underflow); end
    if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_simul();
    logic [DATA_W-1:0] exp_v;
    apply_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
    step(1'b1, 21'h12345, 1'b1);
    checks += 4;
    if (rd_data !== 21'd1)  begin errors++; $display("FAIL fullrw_data: got %h expected 1", rd_data); end
    if (rd_valid !== 1'b1)  begin errors++; $display("FAIL fullrw_valid: got %b expected 1", rd_valid); end
    if (count !== 4'd8)     begin errors++; $display("FAIL fullrw_count: got %0d expected 8", count); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL fullrw_overflow: got %b expected 0", overflow); end
    for (int i = 2; i <= DEPTH + 1; i++) begin
      exp_v = (i <= DEPTH) ? DATA_W'(i) : 21'h12345;
      step(1'b0, '0, 1'b1);
      checks++;
      if (rd_data !== exp_v) begin errors++; $display("FAIL fullrw_drain[%0d]: got %h expected %h", i, rd_data, exp_v); end
    end
  endtask

  task automatic test_empty_simul();
    apply_reset();
    step(1'b1, 21'h00077, 1'b1);
    checks += 4;
    if (underflow !== 1'b1) begin errors++; $display("FAIL emptyrw_underflow: got %b expected 1", underflow); end
    if (rd_valid !== 1'b0)  begin errors++; $display("FAIL emptyrw_valid: got %b expected 0", rd_valid); end
    if (count !== 4'd1)     begin errors++; $display("FAIL emptyrw_count: got %0d expected 1", count); end
    if (rd_data !== '0)     begin errors++; $display("FAIL emptyrw_no_bypass: got %h expected 0", rd_data); end
    step(1'b0, '0, 1'b1);
    checks += 2;
    if (rd_data !== 21'h00077) begin errors++; $display("FAIL emptyrw_read: got %h expected 77", rd_data); end
    if (rd_valid !== 1'b1)     begin errors++; $display("FAIL emptyrw_read_valid: got %b expected 1", rd_valid); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'($urandom), 1'b0);
    checks++;
    if (count !== 4'd5) begin errors++; $display("FAIL arst_prefill: got %0d expected 5", count); end
    #2;
    rst = 1'b1;
    #1;
    // Still between clock edges: the clear must already be visible.
    checks += 3;
    if (count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b expected 1", empty); end
    if (full !== 1'b0)  begin errors++; $display("FAIL arst_full: got %b expected 0", full); end
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b1);
    checks += 2;
    if (underflow !== 1'b1) begin errors++; $display("FAIL arst_underflow: got %b expected 1", underflow); end
    if (rd_valid !== 1'b0)  begin errors++; $display("FAIL arst_no_valid: got %b expected 0", rd_valid); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DATA_W'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DATA_W'($urandom), 1'b1);
      checks += 3;
      if (rd_valid !== m_valid) begin errors++; $display("FAIL wrap_valid[%0d]: got %b expected %b", i, rd_valid, m_valid); end
      if (rd_data !== m_data)   begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rd_data, m_data); end
      if (count !== 4'd3)       begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 3", i, count); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if (rd_data !== m_data) begin errors++; $display("FAIL wrap_drain[%0d]: got %h expected %h", i, rd_data, m_data); end
    end
  endtask

  task automatic test_random();
    logic              wr;
    logic              rd;
    logic [ADDR_W:0]   exp_cnt;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      wr = ($urandom_range(99) < 55);
      rd = ($urandom_range(99) < 45);
      step(wr, DATA_W'($urandom), rd);
      exp_cnt = (ADDR_W+1)'(q.size());
      checks += 7;
      if (rd_valid !== m_valid)  begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, rd_valid, m_valid); end
      if (rd_data !== m_data)    begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, rd_data, m_data); end
      if (count !== exp_cnt)     begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, exp_cnt); end
      if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_full[%0d]: got %b expected %b", i, full, q.size() == DEPTH); end
      if (empty !== (q.size() == 0))    begin errors++; $display("FAIL rand_empty[%0d]: got %b expected %b", i, empty, q.size() == 0); end
      if (overflow !== m_ovf)    begin errors++; $display("FAIL rand_overflow[%0d]: got %b expected %b", i, overflow, m_ovf); end
      if (underflow !== m_udf)   begin errors++; $display("FAIL rand_underflow[%0d]: got %b expected %b", i, underflow, m_udf); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    model_clear();
    #1;
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_simul();
    test_empty_simul();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_fifo.md
Name: result_fifo

Overview:
- Synchronous FIFO directly downstream of the exponential-result datapath.
- Captures each 21-bit scaled result presented with a wr_req pulse.
- Buffers up to DEPTH entries and releases one entry per rd_req pulse from the debounced push-button one-pulser.
- Drives the display/readout path and reports full, empty, occupancy and sticky error flags.

Parameters:
DATA_W, 21, width of each stored result word
DEPTH, 8, number of entries (power of two, minimum 2)
ADDR_W, 3, log2(DEPTH), width of read/write pointers

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous active-high reset
wr_req  input  1  single-cycle write strobe from result datapath
wr_data  input  DATA_W  result word, sampled on the edge where wr_req=1
rd_req  input  1  single-cycle read strobe from one-pulser
rd_data  output  DATA_W  registered output word
rd_valid  output  1  high for exactly one cycle when rd_data has just been loaded
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Storage: DEPTH x DATA_W register array; write pointer wp and read pointer rp, each ADDR_W bits; separate count register of ADDR_W+1 bits.
- Reset (asynchronous, rst=1):
  - wp=0, rp=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Hence empty=1 and full=0.
  - Array contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Write accept: wr_req=1 and (count<DEPTH, or a read is accepted in the same cycle).
  - Effect: mem[wp]<=wr_data and wp<=wp+1, wrapping modulo DEPTH.
- Read accept: rd_req=1 and count>0.
  - Effect: rd_data<=mem[rp], rp<=rp+1 (modulo DEPTH), rd_valid<=1 on the following cycle boundary.
  - Latency: rd_data/rd_valid are valid in the cycle after the rd_req edge.
- rd_valid is 0 in every cycle not immediately following an accepted read.
- rd_data holds its last value until the next accepted read.
- Count update:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged on simultaneous accepted read and write, or when neither is accepted.
- Simultaneous wr_req and rd_req:
  - Empty: write accepted; read rejected; underflow set; count becomes 1. The written word is NOT bypassed to rd_data.
  - Full: both accepted; the oldest word is read and the new word is written into the freed slot (wp==rp case); count stays DEPTH; overflow not set.
  - Otherwise: both accepted; count unchanged.
- Write while full without a read: word dropped, wp unchanged, overflow<=1.
- Read while empty: rd_data unchanged, rd_valid stays 0, underflow<=1.
- overflow/underflow stay set until rst.
- full, empty and count are combinational decodes of the count register (no added latency).
- Pointer wrap: after DEPTH writes, wp returns to 0; ordering is strictly first-in first-out across the wrap.
- No internal FSM beyond the pointer/count logic. The design is fully synchronous apart from the asynchronous reset.

Test Plan:
- Reset then idle: after rst pulse → empty=1, full=0, count=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- Write 21'h000100, 21'h0A5A5, 21'h1FFFFF on three cycles, then three rd_req pulses → rd_data sequence 21'h000100, 21'h0A5A5, 21'h1FFFFF, each with a one-cycle rd_valid the cycle after its rd_req; empty=1 at end.
- Write 8 words (values 1..8) → full=1, count=8. Ninth write of 9 → overflow=1, count=8. Drain 8 → 1..8 in order, and 9 never appears.
- Fill with 8 words, then one cycle with wr_req=1 (value 21'h12345) and rd_req=1 → rd_data=1, count=8, overflow=0. Drain → 2..8 then 21'h12345.
- From empty, wr_req=1 and rd_req=1 in the same cycle (value 21'h00077) → underflow=1, rd_valid=0, count=1. Next rd_req → rd_data=21'h00077.
- Write 5 words, pulse rst asynchronously between clock edges → count=0, empty=1 immediately. Next rd_req → underflow=1, no rd_valid. Wrap test: 12 writes interleaved with 12 reads keep FIFO order.
